// File: rtl/decode_stage_q.sv
// decode_stage_q: queued, registered RV32I decoder with valid/ready output; define RV32M_EN to decode RV32M as muldiv.
module decode_stage_q #(
   parameter int DEPTH     = 4,
   parameter int ILL_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_inst,
   input  logic [31:0]          in_pc,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [18:0]          out_cmd,
   output logic [31:0]          out_imm,
   output logic [2:0]           out_alu_code,
   output logic                 out_alu_sub,
   output logic [4:0]           out_rd,
   output logic [4:0]           out_rs1,
   output logic [4:0]           out_rs2,
   output logic                 out_wbk_rd,
   output logic [31:0]          out_pc,
   output logic                 out_illegal,
   output logic [ILL_CNT_W-1:0] ill_cnt
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0] inst_mem_q [DEPTH];
   logic [31:0] pc_mem_q [DEPTH];
   logic [AW:0] wptr_q, rptr_q;
   logic empty, full, push, load;
   logic [31:0] inst;
   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic sys0;
   logic [18:0] cmd_d, cmd_q;
   logic [31:0] imm_d, imm_q, pc_q;
   logic sub_d, sub_q, wbk_d, wbk_q, ill_d, ill_q, valid_q;
   logic [2:0] code_q;
   logic [4:0] rd_q, rs1_q, rs2_q;
   logic [ILL_CNT_W-1:0] ill_cnt_q;
   assign empty = wptr_q == rptr_q;
   assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign in_ready = ~full;
   assign push = in_valid & ~full & ~flush;
   assign load = ~empty & (~valid_q | out_ready);
   assign inst = inst_mem_q[rptr_q[AW-1:0]];
   assign opc = inst[6:0];
   assign f3 = inst[14:12];
   assign f7 = inst[31:25];
   assign sys0 = opc == 7'b1110011 && inst[19:7] == 13'h0;
   always_comb begin
      cmd_d = '0;
      cmd_d[0] = opc == 7'b0110111;
      cmd_d[1] = opc == 7'b0010111;
      cmd_d[2] = opc == 7'b0000011;
      cmd_d[3] = opc == 7'b0010011 && f3 != 3'b001 && f3 != 3'b101;
      cmd_d[4] = opc == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101)
                 && (f7 == 7'b0000000 || (f7 == 7'b0100000 && f3 == 3'b101));
      cmd_d[5] = opc == 7'b0110011
                 && (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      cmd_d[6] = opc == 7'b0100011;
      cmd_d[7] = opc == 7'b1101111;
      cmd_d[8] = opc == 7'b1100111;
      cmd_d[9] = opc == 7'b1100011;
      cmd_d[10] = opc == 7'b0001111 && f3 == 3'b000 && inst[11:7] == 5'h0 && inst[19:15] == 5'h0;
      cmd_d[11] = opc == 7'b0001111 && f3 == 3'b001 && inst[11:7] == 5'h0 && inst[19:15] == 5'h0
                  && inst[31:20] == 12'h0;
      cmd_d[12] = opc == 7'b1110011 && f3 != 3'b000 && f3 != 3'b100;
      cmd_d[13] = sys0 && inst[31:20] == 12'h000;
      cmd_d[14] = sys0 && inst[31:20] == 12'h001;
      cmd_d[15] = sys0 && inst[31:20] == 12'h302;
      cmd_d[16] = sys0 && inst[31:20] == 12'h102;
      cmd_d[17] = sys0 && inst[31:20] == 12'h105;
`ifdef RV32M_EN
      cmd_d[18] = opc == 7'b0110011 && f7 == 7'b0000001;
`else
      cmd_d[18] = 1'b0;
`endif
   end
   assign imm_d = (cmd_d[2] | cmd_d[3] | cmd_d[8] | cmd_d[12]) ? {{20{inst[31]}}, inst[31:20]} :
                  cmd_d[6] ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                  cmd_d[9] ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                  (cmd_d[0] | cmd_d[1]) ? {inst[31:12], 12'h0} :
                  cmd_d[7] ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : 32'h0;
   assign sub_d = (cmd_d[4] | cmd_d[5]) & inst[30];
   assign wbk_d = (|{cmd_d[18], cmd_d[12], cmd_d[8:7], cmd_d[5:0]}) && inst[11:7] != 5'h0;
   assign ill_d = ~|cmd_d;
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[wptr_q[AW-1:0]] <= in_inst;
         pc_mem_q[wptr_q[AW-1:0]] <= in_pc;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         valid_q <= 1'b0;
         cmd_q <= '0;
         imm_q <= '0;
         code_q <= '0;
         sub_q <= 1'b0;
         rd_q <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
         wbk_q <= 1'b0;
         pc_q <= '0;
         ill_q <= 1'b0;
         ill_cnt_q <= '0;
      end else if (flush) begin
         wptr_q <= rptr_q;
         valid_q <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (load) begin
            rptr_q <= rptr_q + 1'b1;
            valid_q <= 1'b1;
            cmd_q <= cmd_d;
            imm_q <= imm_d;
            code_q <= f3;
            sub_q <= sub_d;
            rd_q <= inst[11:7];
            rs1_q <= inst[19:15];
            rs2_q <= inst[24:20];
            wbk_q <= wbk_d;
            pc_q <= pc_mem_q[rptr_q[AW-1:0]];
            ill_q <= ill_d;
         end else if (out_ready) valid_q <= 1'b0;
         if (valid_q && out_ready && ill_q && ill_cnt_q != {ILL_CNT_W{1'b1}}) ill_cnt_q <= ill_cnt_q + 1'b1;
      end
   end
   assign out_valid = valid_q;
   assign out_cmd = cmd_q;
   assign out_imm = imm_q;
   assign out_alu_code = code_q;
   assign out_alu_sub = sub_q;
   assign out_rd = rd_q;
   assign out_rs1 = rs1_q;
   assign out_rs2 = rs2_q;
   assign out_wbk_rd = wbk_q;
   assign out_pc = pc_q;
   assign out_illegal = ill_q;
   assign ill_cnt = ill_cnt_q;
endmodule

// File: tb/tb_decode_stage_q.sv
// tb_decode_stage_q: directed self-checking bench; a second instance with ILL_CNT_W=2 shows counter saturation.
module tb_decode_stage_q;
   logic clk = 1'b0, rst_n, in_valid, flush, out_ready;
   logic [31:0] in_inst, in_pc;
   logic in_ready, out_valid, out_alu_sub, out_wbk_rd, out_illegal;
   logic [18:0] out_cmd;
   logic [31:0] out_imm, out_pc;
   logic [2:0] out_alu_code;
   logic [4:0] out_rd, out_rs1, out_rs2;
   logic [7:0] ill_cnt;
   logic d2_in_ready, d2_out_valid, d2_out_alu_sub, d2_out_wbk_rd, d2_out_illegal;
   logic [18:0] d2_out_cmd;
   logic [31:0] d2_out_imm, d2_out_pc;
   logic [2:0] d2_out_alu_code;
   logic [4:0] d2_out_rd, d2_out_rs1, d2_out_rs2;
   logic [1:0] d2_ill_cnt;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   decode_stage_q #(.DEPTH(4), .ILL_CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
      .out_imm(out_imm), .out_alu_code(out_alu_code), .out_alu_sub(out_alu_sub), .out_rd(out_rd),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_wbk_rd(out_wbk_rd), .out_pc(out_pc),
      .out_illegal(out_illegal), .ill_cnt(ill_cnt));
   decode_stage_q #(.DEPTH(4), .ILL_CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .flush(flush), .out_valid(d2_out_valid), .out_ready(out_ready), .out_cmd(d2_out_cmd),
      .out_imm(d2_out_imm), .out_alu_code(d2_out_alu_code), .out_alu_sub(d2_out_alu_sub), .out_rd(d2_out_rd),
      .out_rs1(d2_out_rs1), .out_rs2(d2_out_rs2), .out_wbk_rd(d2_out_wbk_rd), .out_pc(d2_out_pc),
      .out_illegal(d2_out_illegal), .ill_cnt(d2_ill_cnt));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_cmd !== 19'h0 || out_imm !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL reset_data got cmd=%h imm=%h pc=%h exp 0", out_cmd, out_imm, out_pc); end
      checks++; if (ill_cnt !== 8'h0) begin errors++; $display("FAIL reset_ill_cnt got %0d exp 0", ill_cnt); end
      rst_n = 1'b1;
   endtask
   task automatic test_addi();
      in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h100;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_early got %b exp 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_cmd !== 19'h8) begin errors++; $display("FAIL addi_cmd got v=%b cmd=%h exp v=1 cmd=00008", out_valid, out_cmd); end
      checks++; if (out_imm !== 32'h5 || out_rd !== 5'd1 || out_pc !== 32'h100) begin errors++; $display("FAIL addi_fields got imm=%h rd=%0d pc=%h exp 5/1/100", out_imm, out_rd, out_pc); end
      checks++; if (out_wbk_rd !== 1'b1 || out_illegal !== 1'b0) begin errors++; $display("FAIL addi_flags got wbk=%b ill=%b exp 1/0", out_wbk_rd, out_illegal); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %b exp 0", out_valid); end
   endtask
   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid = 1'b1; in_inst = 32'h12345137; in_pc = 32'h200;
      tick();
      in_inst = 32'hFE000EE3; in_pc = 32'h204;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_cmd !== 19'h1 || out_imm !== 32'h12345000 || out_rd !== 5'd2) begin errors++; $display("FAIL lui got v=%b cmd=%h imm=%h rd=%0d exp 1/00001/12345000/2", out_valid, out_cmd, out_imm, out_rd); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_cmd !== 19'h200 || out_imm !== 32'hFFFFFFFC || out_pc !== 32'h204) begin errors++; $display("FAIL beq got v=%b cmd=%h imm=%h pc=%h exp 1/00200/fffffffc/204", out_valid, out_cmd, out_imm, out_pc); end
      checks++; if (out_wbk_rd !== 1'b0) begin errors++; $display("FAIL beq_wbk got %b exp 0", out_wbk_rd); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
   endtask
   task automatic test_alu_fields();
      out_ready = 1'b1;
      in_valid = 1'b1; in_inst = 32'h407302B3;
      tick();
      in_inst = 32'h4030D093;
      tick();
      in_inst = 32'h00000073;
      checks++; if (out_cmd !== 19'h20 || out_alu_sub !== 1'b1 || out_rd !== 5'd5 || out_rs1 !== 5'd6 || out_rs2 !== 5'd7) begin errors++; $display("FAIL sub got cmd=%h sub=%b rd=%0d rs1=%0d rs2=%0d exp 00020/1/5/6/7", out_cmd, out_alu_sub, out_rd, out_rs1, out_rs2); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_cmd !== 19'h10 || out_alu_sub !== 1'b1 || out_alu_code !== 3'b101 || out_imm !== 32'h0) begin errors++; $display("FAIL srai got cmd=%h sub=%b code=%0d imm=%h exp 00010/1/5/0", out_cmd, out_alu_sub, out_alu_code, out_imm); end
      tick();
      checks++; if (out_cmd !== 19'h2000 || out_wbk_rd !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("FAIL ecall got cmd=%h wbk=%b ill=%b exp 02000/0/0", out_cmd, out_wbk_rd, out_illegal); end
      tick();
   endtask
   task automatic test_full();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d got %b exp 1", i, in_ready); end
         in_valid = 1'b1; in_inst = {12'(10 + i), 5'd0, 3'd0, 5'(i + 1), 7'h13}; in_pc = 32'h300 + 32'(4 * i);
         tick();
      end
      in_inst = 32'h06300793; in_pc = 32'h3FC;
      tick();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || out_imm !== 32'd10 || out_pc !== 32'h300) begin errors++; $display("FAIL full_hold got v=%b imm=%0d pc=%h exp 1/10/300", out_valid, out_imm, out_pc); end
      out_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || out_imm !== 32'(10 + k) || out_rd !== 5'(k + 1)) begin errors++; $display("FAIL drain_%0d got v=%b imm=%0d rd=%0d exp 1/%0d/%0d", k, out_valid, out_imm, out_rd, 10 + k, k + 1); end
      end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_extra got %b exp 0", out_valid); end
   endtask
   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h400 + 32'(4 * i);
         tick();
      end
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL preflush got v=%b rdy=%b exp 1/1", out_valid, in_ready); end
      flush = 1'b1; in_inst = 32'h00700393; in_pc = 32'h4F0;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ill_cnt !== 8'd0) begin errors++; $display("FAIL flush got v=%b rdy=%b cnt=%0d exp 0/1/0", out_valid, in_ready, ill_cnt); end
      out_ready = 1'b1;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b exp 0", out_valid); end
   endtask
   task automatic test_illegal();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_inst = 32'hFFFFFFFF; in_pc = 32'h500 + 32'(4 * i);
         tick();
         if (i >= 1) begin
            checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_cmd !== 19'h0) begin errors++; $display("FAIL ill_bundle_%0d got v=%b ill=%b cmd=%h exp 1/1/0", i, out_valid, out_illegal, out_cmd); end
            checks++; if (ill_cnt !== 8'(i - 1)) begin errors++; $display("FAIL ill_cnt_%0d got %0d exp %0d", i, ill_cnt, i - 1); end
         end
      end
      in_valid = 1'b0;
      tick(); tick();
      checks++; if (ill_cnt !== 8'd5) begin errors++; $display("FAIL ill_cnt_final got %0d exp 5", ill_cnt); end
      checks++; if (d2_ill_cnt !== 2'd3) begin errors++; $display("FAIL ill_cnt_sat got %0d exp 3", d2_ill_cnt); end
   endtask
   task automatic test_mul();
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h022081B3; in_pc = 32'h600;
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (out_rd !== 5'd3 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin errors++; $display("FAIL mul_regs got rd=%0d rs1=%0d rs2=%0d exp 3/1/2", out_rd, out_rs1, out_rs2); end
`ifdef RV32M_EN
      checks++; if (out_cmd !== 19'h40000 || out_illegal !== 1'b0 || out_wbk_rd !== 1'b1) begin errors++; $display("FAIL mul_cmd got cmd=%h ill=%b wbk=%b exp 40000/0/1", out_cmd, out_illegal, out_wbk_rd); end
`else
      checks++; if (out_cmd !== 19'h0 || out_illegal !== 1'b1) begin errors++; $display("FAIL mul_cmd got cmd=%h ill=%b exp 0/1", out_cmd, out_illegal); end
`endif
      out_ready = 1'b1;
      tick();
   endtask
   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_alu_fields();
      test_full();
      test_flush();
      test_illegal();
      test_mul();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end
endmodule

// File: doc/decode_stage_q.md
Name: decode_stage_q

Overview:
- Registered, parametrised successor to the combinational RV32I instruction decoder.
- Buffers fetched instructions in a DEPTH-entry queue and decodes the head entry.
- Generates the sign-extended immediate for every format.
- Presents a registered decode bundle to EX under a valid/ready handshake, with flush and a saturating illegal-instruction counter.
- Sits between IF and EX; optionally decodes RV32M.

Parameters:
DEPTH, 4, instruction queue entries; power of 2, >=2
ILL_CNT_W, 8, width of saturating illegal-instruction counter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  IF presents inst/pc
in_ready  output  1  queue can accept (not full)
in_inst  input  32  instruction word
in_pc  input  32  instruction address
flush  input  1  discard queue and output register (branch/trap redirect)
out_valid  output  1  decode bundle valid
out_ready  input  1  EX accepts bundle
out_cmd  output  19  one-hot command: 0 lui,1 auipc,2 ld,3 alui,4 alui_shamt,5 alu,6 st,7 jal,8 jalr,9 br,10 fence,11 fencei,12 csr,13 ecall,14 ebreak,15 mret,16 sret,17 wfi,18 muldiv
out_imm  output  32  sign-extended immediate
out_alu_code  output  3  inst[14:12]
out_alu_sub  output  1  inst[30] for alu (sub/sra); inst[30] for alui_shamt (srai)
out_rd  output  5  inst[11:7]
out_rs1  output  5  inst[19:15]
out_rs2  output  5  inst[24:20]
out_wbk_rd  output  1  command writes rd (not st/br/fence/ecall-group), rd!=0
out_pc  output  32  pc of bundle
out_illegal  output  1  no legal command matched (nop 0x00000013 is legal alui)
ill_cnt  output  ILL_CNT_W  illegal instructions accepted by EX

Behaviour:
- Reset (rst_n low at posedge):
  - queue empty; read/write pointers 0.
  - out_valid=0; all out_* data=0; ill_cnt=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all content.
- Queue:
  - Push when in_valid & in_ready.
  - in_ready = ~full, computed from registered state only. No push when full, even if a pop occurs the same cycle.
  - Pointers wrap mod DEPTH; full/empty tracked with an extra pointer bit.
- Output register:
  - Loads decode of head entry when queue non-empty and (out_valid==0 | out_ready==1); pops head in the same cycle.
  - If queue is empty and out_ready=1, out_valid drops to 0.
  - While out_valid & ~out_ready, all out_* hold stable.
- Latency:
  - Instruction pushed at edge t appears with out_valid=1 after edge t+1 when queue and output register are empty.
  - Sustained throughput is 1 instruction/cycle.
- Decode rules:
  - Opcode classes and fence/ecall/mret/sret/wfi zero-field checks per RV32I. sfence is not decoded (illegal).
  - inst[1:0] != 2'b11 is illegal.
  - alu requires funct7 in {0000000, 0100000 with funct3 000/101}.
  - alui_shamt requires inst[31:25] in {0000000, 0100000 with funct3 101}.
  - csr requires funct3 != 000 and != 100.
  - Exactly one out_cmd bit is set, or zero bits with out_illegal=1.
- Immediate:
  - I (ld, alui, jalr, csr): inst[31:20] sign-extended.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'h0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All sign-extended to 32 bits; all other commands 0.
- Flush:
  - flush=1 at edge empties the queue and clears out_valid.
  - A push presented in the same cycle is dropped.
  - ill_cnt is unchanged.
  - Flush has priority over push, pop and output load.
- ill_cnt:
  - Increments when out_valid & out_ready & out_illegal.
  - Saturates at 2^ILL_CNT_W-1.

Optional Feature:
- Macro RV32M_EN.
- Defined: opcode 0110011 with funct7 0000001 sets out_cmd[18] (muldiv); out_alu_code carries the M funct3; out_wbk_rd follows rd.
- Undefined: that encoding is illegal and out_cmd[18] is tied 0.

Test Plan:
- Reset then push 0x00500093 (addi x1,x0,5) -> two edges later: out_valid=1, out_cmd[3]=1, out_imm=5, out_rd=1, out_wbk_rd=1, out_illegal=0.
- Push 0x12345137 (lui x2) then 0xFE000EE3 (beq x0,x0,-4) with out_ready=1 -> bundles in order:
  - lui: out_imm=0x12345000.
  - beq: out_cmd[9]=1, out_imm=0xFFFFFFFC, out_wbk_rd=0.
- out_ready=0, push DEPTH+1 instructions -> in_ready=0 once queue full, bundle held stable. Release out_ready -> all DEPTH+1 emerge in order, no loss or duplication.
- Queue holding 3 entries with out_valid=1, pulse flush together with in_valid -> next cycle out_valid=0, queue empty, pushed instruction absent.
- Push 0xFFFFFFFF ×3 accepted by EX -> out_illegal=1 each, ill_cnt=3. With ILL_CNT_W=2, 5 illegals -> ill_cnt=3 (saturated).
- Push 0x022081B3 (mul x3,x1,x2):
  - With RV32M_EN -> out_cmd[18]=1, out_rd=3, rs1=1, rs2=2.
  - Without -> out_illegal=1.
